sync_filter: RTL and testbench

- Parametrised N-channel input synchroniser with a per-channel stability filter and edge detection.
- Each asynchronous input passes through a STAGES-deep flop chain that resets to a per-channel value.
- A counter then requires FILTER_CNT consecutive agreeing samples before the filtered output changes.
- Sits at the USB PHY boundary (d_plus/d_minus and similar pad inputs) in front of the edge detector and decoder, which consume the filtered levels and the rise/fall pulses.

---
 rtl/sync_filter_pkg.sv | 5 +
 rtl/sync_filter_chan.sv | 74 +++++++
 rtl/sync_filter.sv | 35 +++
 tb/tb_sync_filter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sync_filter_pkg.sv
// Default constants for the USB pad-input front end.
package sync_filter_pkg;
   localparam logic [1:0] USB_IDLE_J          = 2'b01;
   localparam int         SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/sync_filter_chan.sv
// One channel: reset-valued synchroniser chain, stability filter and registered edge pulses.
module sync_filter_chan #(
   parameter int   STAGES     = 2,
   parameter int   FILTER_CNT = 4,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   input  logic i_filt_en,
   output logic o_sync,
   output logic o_filt,
   output logic o_rise,
   output logic o_fall
);
   localparam int            CW      = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CNT - 1);

   generate
      if (STAGES < 2) begin : g_bad_stages
         $fatal(1, "sync_filter_chan: STAGES must be >= 2");
      end
      if (FILTER_CNT < 1) begin : g_bad_cnt
         $fatal(1, "sync_filter_chan: FILTER_CNT must be >= 1");
      end
   endgenerate

   logic [STAGES-1:0] r_sync;
   logic [CW-1:0]     r_cnt;
   logic              r_filt;
   logic              r_rise;
   logic              r_fall;
   logic              w_s;
   logic              w_filt_nxt;
   logic [CW-1:0]     w_cnt_nxt;

   assign w_s = r_sync[STAGES-1];

   // Any agreement, bypass or accepted change clears the count, so it never wraps.
   always_comb begin
      w_filt_nxt = r_filt;
      w_cnt_nxt  = '0;
      if (!i_filt_en) begin
         w_filt_nxt = w_s;
      end else if (w_s != r_filt) begin
         if (r_cnt == CNT_MAX) begin
            w_filt_nxt = w_s;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_cnt  <= '0;
         r_filt <= RST_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
         r_cnt  <= w_cnt_nxt;
         r_filt <= w_filt_nxt;
         r_rise <= w_filt_nxt & ~r_filt;
         r_fall <= ~w_filt_nxt & r_filt;
      end
   end

   assign o_sync = w_s;
   assign o_filt = r_filt;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
endmodule

// File: rtl/sync_filter.sv
// N independent pad-input channels, each synchronised, stability-filtered and edge-detected.
module sync_filter
   import sync_filter_pkg::*;
#(
   parameter int                NUM_CH     = 2,
   parameter int                STAGES     = SYNC_STAGES_DEFAULT,
   parameter int                FILTER_CNT = 4,
   parameter logic [NUM_CH-1:0] RST_VAL    = USB_IDLE_J
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] async_in,
   input  logic              filt_en,
   output logic [NUM_CH-1:0] sync_out,
   output logic [NUM_CH-1:0] filt_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sync_filter_chan #(
         .STAGES     (STAGES),
         .FILTER_CNT (FILTER_CNT),
         .RST_VAL    (RST_VAL[i])
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_async   (async_in[i]),
         .i_filt_en (filt_en),
         .o_sync    (sync_out[i]),
         .o_filt    (filt_out[i]),
         .o_rise    (rise[i]),
         .o_fall    (fall[i])
      );
   end
endmodule

// File: tb/tb_sync_filter.sv
// Directed checks on a default instance plus a randomized sweep of a re-parameterised instance.
module tb_sync_filter;
   logic       clk;
   logic       rst_a, rst_s;
   logic       en_a, en_b;
   logic [1:0] async_a, sync_a, filt_a, rise_a, fall_a;
   logic [3:0] async_b, sync_b, filt_b, rise_b, fall_b;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   sync_filter dut_a (
      .clk(clk), .rst(rst_a), .async_in(async_a), .filt_en(en_a),
      .sync_out(sync_a), .filt_out(filt_a), .rise(rise_a), .fall(fall_a)
   );

   sync_filter #(.NUM_CH(4), .STAGES(3), .FILTER_CNT(1), .RST_VAL(4'b1010)) dut_b (
      .clk(clk), .rst(rst_s), .async_in(async_b), .filt_en(en_b),
      .sync_out(sync_b), .filt_out(filt_b), .rise(rise_b), .fall(fall_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic [1:0] ef, input logic [1:0] er,
                        input logic [1:0] efl);
      chk({tag, "_filt"}, 4'(filt_a), 4'(ef));
      chk({tag, "_rise"}, 4'(rise_a), 4'(er));
      chk({tag, "_fall"}, 4'(fall_a), 4'(efl));
   endtask

   // async_a must already be 2'b10; filt must move 01 -> 10 exactly six edges after release.
   task automatic release_and_check(input string tag);
      @(posedge clk);
      #1 rst_a = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_a(tag, (k >= 6) ? 2'b10 : 2'b01, (k == 6) ? 2'b10 : 2'b00,
               (k == 6) ? 2'b01 : 2'b00);
      end
   endtask

   // Channel 0 held low for len sampled edges from a settled all-ones state.
   task automatic low_pulse(input int len, input string tag);
      logic [1:0] ef, er, efl;
      async_a = 2'b10;
      for (int t = 1; t <= 14; t++) begin
         tick();
         ef  = (len >= 4 && t >= 6 && t <= len + 5) ? 2'b10 : 2'b11;
         er  = (len >= 4 && t == len + 6) ? 2'b01 : 2'b00;
         efl = (len >= 4 && t == 6) ? 2'b01 : 2'b00;
         chk_a(tag, ef, er, efl);
         if (t == len) async_a = 2'b11;
      end
   endtask

   logic [3:0] hist[$];
   logic [3:0] ef_b, prev_b;

   initial begin
      rst_a = 1'b0; rst_s = 1'b0;
      en_a = 1'b1; en_b = 1'b1;
      async_a = 2'b10; async_b = 4'b0101;

      // Reset is asynchronous: outputs settle before any clock edge.
      #2 rst_a = 1'b1; rst_s = 1'b1;
      #1;
      chk("rst_sync", 4'(sync_a), 4'b0001);
      chk_a("rst", 2'b01, 2'b00, 2'b00);
      chk("rstb_sync", sync_b, 4'b1010);
      chk("rstb_filt", filt_b, 4'b1010);
      chk("rstb_edges", rise_b | fall_b, 4'b0000);
      tick(); tick();
      chk("rst_hold_sync", 4'(sync_a), 4'b0001);
      chk_a("rst_hold", 2'b01, 2'b00, 2'b00);

      release_and_check("t1");

      async_a = 2'b11;
      for (int t = 1; t <= 7; t++) begin
         tick();
         chk_a("settle", (t >= 6) ? 2'b11 : 2'b10, (t == 6) ? 2'b01 : 2'b00, 2'b00);
      end

      low_pulse(3, "glitch3");
      low_pulse(4, "glitch4");

      en_a = 1'b0;
      tick();
      chk_a("byp_idle", 2'b11, 2'b00, 2'b00);
      async_a = 2'b01;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("byp_sync", 4'(sync_a), (t == 2) ? 4'b0001 : 4'b0011);
         chk_a("byp", (t == 3) ? 2'b01 : 2'b11, (t == 4) ? 2'b10 : 2'b00,
               (t == 3) ? 2'b10 : 2'b00);
         if (t == 1) async_a = 2'b11;
      end

      en_a = 1'b1;
      tick();
      async_a = 2'b10;
      for (int t = 1; t <= 4; t++) begin
         tick();
         chk_a("sw_pend", 2'b11, 2'b00, 2'b00);
      end
      en_a = 1'b0;
      tick();
      chk_a("sw_byp", 2'b10, 2'b00, 2'b01);
      en_a = 1'b1;
      async_a = 2'b11;
      for (int t = 1; t <= 7; t++) begin
         tick();
         chk_a("sw_reen", (t >= 6) ? 2'b11 : 2'b10, (t == 6) ? 2'b01 : 2'b00, 2'b00);
      end

      async_a = 2'b10;
      for (int t = 1; t <= 5; t++) begin
         tick();
         chk_a("mid_pend", 2'b11, 2'b00, 2'b00);
      end
      #3 rst_a = 1'b1;
      #1;
      chk("mid_rst_sync", 4'(sync_a), 4'b0001);
      chk_a("mid_rst", 2'b01, 2'b00, 2'b00);
      tick();
      chk_a("mid_rst_hold", 2'b01, 2'b00, 2'b00);
      release_and_check("t5");

      // Sweep: with FILTER_CNT=1 and STAGES=3, filt_out after edge n is the input sampled at edge n-3.
      async_b = 4'($urandom);
      @(posedge clk);
      #1 rst_s = 1'b0;
      hist = '{4'b1010, 4'b1010, 4'b1010, 4'b1010};
      for (int n = 1; n <= 120; n++) begin
         @(posedge clk);
         hist.push_back(async_b);
         #1;
         ef_b   = hist[$-3];
         prev_b = hist[$-4];
         chk("swp_sync", sync_b, hist[$-2]);
         chk("swp_filt", filt_b, ef_b);
         chk("swp_rise", rise_b, ef_b & ~prev_b);
         chk("swp_fall", fall_b, ~ef_b & prev_b);
         chk("swp_overlap", rise_b & fall_b, 4'b0000);
         if (n >= 110) async_b = async_b;
         else begin
            #($urandom_range(0, 7));
            async_b = 4'($urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
